// File: rtl/issue_queue_param.sv
// Out-of-order issue queue: tag wakeup broadcast, oldest-first select relative to the
// active-list head, single-entry output register, and age-based partial flush.
module issue_queue_param #(
   parameter int DEPTH     = 16,
   parameter int TAG_W     = 6,
   parameter int AGE_W     = 5,
   parameter int PAYLOAD_W = 64,
   parameter int NUM_WK    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2*TAG_W-1:0]         in_tag,
   input  logic [1:0]                 in_rdy,
   input  logic [AGE_W-1:0]           in_age,
   input  logic [PAYLOAD_W-1:0]       in_payload,
   input  logic [NUM_WK-1:0]          wk_valid,
   input  logic [NUM_WK*TAG_W-1:0]    wk_tag,
   input  logic                       flush,
   input  logic                       flush_all,
   input  logic [AGE_W-1:0]           flush_age,
   input  logic [AGE_W-1:0]           al_head,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [AGE_W-1:0]           out_age,
   output logic [2*TAG_W-1:0]         out_tag,
   output logic [PAYLOAD_W-1:0]       out_payload,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   function automatic logic wk_hit(
      input logic [TAG_W-1:0]        tag,
      input logic [NUM_WK-1:0]       v,
      input logic [NUM_WK*TAG_W-1:0] tags
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_WK; k++) begin
         hit = hit | (v[k] & (tags[k*TAG_W +: TAG_W] == tag));
      end
      return hit;
   endfunction

   // Distance from the active-list head; modular so ages may wrap past 2^AGE_W.
   function automatic logic [AGE_W-1:0] rel_age(
      input logic [AGE_W-1:0] age,
      input logic [AGE_W-1:0] head
   );
      return age - head;
   endfunction

   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     rdy1_q, rdy1_d;
   logic [DEPTH-1:0]     rdy2_q, rdy2_d;
   logic [TAG_W-1:0]     tag1_q    [DEPTH];
   logic [TAG_W-1:0]     tag1_d    [DEPTH];
   logic [TAG_W-1:0]     tag2_q    [DEPTH];
   logic [TAG_W-1:0]     tag2_d    [DEPTH];
   logic [AGE_W-1:0]     age_q     [DEPTH];
   logic [AGE_W-1:0]     age_d     [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [PAYLOAD_W-1:0] payload_d [DEPTH];

   logic                 out_valid_q, out_valid_d;
   logic [AGE_W-1:0]     out_age_q, out_age_d;
   logic [2*TAG_W-1:0]   out_tag_q, out_tag_d;
   logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic [DEPTH-1:0]     kill_s;
   logic [DEPTH-1:0]     elig_s;
   logic                 out_kill_s;
   logic [AGE_W-1:0]     flush_rel_s;
   logic                 sel_found_s;
   logic [IDX_W-1:0]     sel_idx_s;
   logic [AGE_W-1:0]     best_rel_s;
   logic                 free_found_s;
   logic [IDX_W-1:0]     free_idx_s;
   logic                 in_ready_s;
   logic                 dispatch_s;
   logic                 out_load_s;

   // Kill mask and eligibility; a killed entry is never offered to select.
   always_comb begin
      flush_rel_s = rel_age(flush_age, al_head);
      kill_s      = '0;
      elig_s      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill_s[i] = flush & (flush_all | (rel_age(age_q[i], al_head) > flush_rel_s));
         elig_s[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i] & ~kill_s[i];
      end
      out_kill_s = flush & (flush_all | (rel_age(out_age_q, al_head) > flush_rel_s));
   end

   // Oldest eligible entry; strict compare keeps the lowest index on a tie.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      best_rel_s  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (elig_s[i] && (!sel_found_s || (rel_age(age_q[i], al_head) < best_rel_s))) begin
            sel_found_s = 1'b1;
            sel_idx_s   = IDX_W'(i);
            best_rel_s  = rel_age(age_q[i], al_head);
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // Lowest-indexed free slot for dispatch.
   always_comb begin
      free_found_s = ~&valid_q;
      free_idx_s   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx_s = IDX_W'(i);
         end else begin
            free_idx_s = free_idx_s;
         end
      end
   end

   // Handshake decisions for this cycle.
   always_comb begin
      in_ready_s = (count_q < CNT_W'(DEPTH)) & ~flush;
      dispatch_s = in_valid & in_ready_s & free_found_s;
      out_load_s = (~out_valid_q | out_ready) & sel_found_s;
   end

   // Entry array next state: wakeup, issue invalidation, flush kill, dispatch write.
   always_comb begin
      valid_d   = valid_q & ~kill_s;
      tag1_d    = tag1_q;
      tag2_d    = tag2_q;
      age_d     = age_q;
      payload_d = payload_q;
      for (int i = 0; i < DEPTH; i++) begin
         rdy1_d[i] = rdy1_q[i] | wk_hit(tag1_q[i], wk_valid, wk_tag);
         rdy2_d[i] = rdy2_q[i] | wk_hit(tag2_q[i], wk_valid, wk_tag);
      end
      if (out_load_s) begin
         valid_d[sel_idx_s] = 1'b0;
      end else begin
         valid_d = valid_d;
      end
      if (dispatch_s) begin
         valid_d[free_idx_s]   = 1'b1;
         tag1_d[free_idx_s]    = in_tag[TAG_W-1:0];
         tag2_d[free_idx_s]    = in_tag[2*TAG_W-1:TAG_W];
         rdy1_d[free_idx_s]    = in_rdy[0] | wk_hit(in_tag[TAG_W-1:0], wk_valid, wk_tag);
         rdy2_d[free_idx_s]    = in_rdy[1] | wk_hit(in_tag[2*TAG_W-1:TAG_W], wk_valid, wk_tag);
         age_d[free_idx_s]     = in_age;
         payload_d[free_idx_s] = in_payload;
      end else begin
         valid_d = valid_d;
      end
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + CNT_W'(valid_d[i]);
      end
   end

   // Output register: load when free or draining, otherwise hold unless consumed or killed.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_age_d     = out_age_q;
      out_tag_d     = out_tag_q;
      out_payload_d = out_payload_q;
      if (out_load_s) begin
         out_valid_d   = 1'b1;
         out_age_d     = age_q[sel_idx_s];
         out_tag_d     = {tag2_q[sel_idx_s], tag1_q[sel_idx_s]};
         out_payload_d = payload_q[sel_idx_s];
      end else if (out_kill_s || out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Control state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         rdy1_q      <= '0;
         rdy2_q      <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         valid_q     <= valid_d;
         rdy1_q      <= rdy1_d;
         rdy2_q      <= rdy2_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
      end
   end

   // Data storage is qualified by the valid bits and needs no reset.
   always_ff @(posedge clk) begin
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      age_q         <= age_d;
      payload_q     <= payload_d;
      out_age_q     <= out_age_d;
      out_tag_q     <= out_tag_d;
      out_payload_q <= out_payload_d;
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_q;
   assign out_age     = out_age_q;
   assign out_tag     = out_tag_q;
   assign out_payload = out_payload_q;
   assign count       = count_q;

endmodule
